// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session sequencer.
// States, transaction codes and mini-statement history depth.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIN_WAIT,
        ST_TXN_WAIT,
        ST_EXECUTE,
        ST_EJECT,
        ST_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        TXN_WITHDRAW = 2'b00,
        TXN_DEPOSIT  = 2'b01,
        TXN_BALANCE  = 2'b10,
        TXN_CANCEL   = 2'b11
    } txn_t;

    localparam int HIST_DEPTH = 4;

endpackage

// File: rtl/atm_timeout_timer.sv
// Restartable inactivity down-counter: expired is raised while enabled once
// TIMEOUT_CYC cycles have elapsed since the last restart.
module atm_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = LOAD_VAL;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == '0);

endmodule

// File: rtl/atm_session_sequencer.sv
// One ATM customer session: card detect, PIN check with lockout, one transaction, eject.
// Optional macro ATM_MINI_STATEMENT_EN adds a 4-entry history of committed balances.
module atm_session_sequencer
    import atm_pkg::*;
#(
    parameter int               PIN_W         = 16,
    parameter int               BAL_W         = 16,
    parameter logic [PIN_W-1:0] STORED_PIN    = 16'h1234,
    parameter int               MAX_PIN_TRIES = 3,
    parameter int               TIMEOUT_CYC   = 1000,
    parameter logic [BAL_W-1:0] INIT_BALANCE  = 16'd5000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             card_inserted,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_value,
    input  logic             txn_valid,
    input  logic [1:0]       txn_type,
    input  logic [BAL_W-1:0] txn_amount,
    input  logic [1:0]       stmt_idx,
    output logic             pin_ok,
    output logic             card_eject,
    output logic             card_retained,
    output logic             withdrawal_completed,
    output logic             deposit_completed,
    output logic             txn_error,
    output logic [BAL_W-1:0] old_balance,
    output logic [BAL_W-1:0] new_balance,
    output logic [BAL_W-1:0] mini_statement,
    output logic             busy
);

    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);

    state_t           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic             pin_ok_q, pin_ok_d;
    logic             timer_restart, timer_enable, timer_expired;

    txn_t             type_q, type_d;
    logic [BAL_W-1:0] amt_q, amt_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [BAL_W-1:0] old_q, old_d;
    logic [BAL_W-1:0] new_q, new_d;
    logic             wd_q, wd_d;
    logic             dep_q, dep_d;
    logic             err_q, err_d;
    logic [BAL_W:0]   dep_sum;

    atm_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(timer_restart),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tries_q  <= '0;
            pin_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            pin_ok_q <= pin_ok_d;
        end
    end

    // Card removal beats any same-cycle strobe, and a strobe beats the timeout.
    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        pin_ok_d  = pin_ok_q;
        tries_inc = tries_q + TRY_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (card_inserted) state_d = ST_PIN_WAIT;
            end
            ST_PIN_WAIT: begin
                if (!card_inserted) begin
                    state_d = ST_IDLE;
                end else if (pin_valid) begin
                    if (pin_value == STORED_PIN) begin
                        state_d  = ST_TXN_WAIT;
                        tries_d  = '0;
                        pin_ok_d = 1'b1;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TRY_W'(MAX_PIN_TRIES)) state_d = ST_LOCKED;
                    end
                end else if (timer_expired) begin
                    state_d = ST_EJECT;
                end
            end
            ST_TXN_WAIT: begin
                if (!card_inserted) begin
                    state_d = ST_IDLE;
                end else if (txn_valid) begin
                    state_d = (txn_t'(txn_type) == TXN_CANCEL) ? ST_EJECT : ST_EXECUTE;
                end else if (timer_expired) begin
                    state_d = ST_EJECT;
                end
            end
            ST_EXECUTE: state_d = ST_EJECT;
            ST_EJECT: begin
                if (!card_inserted) state_d = ST_IDLE;
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            tries_d  = '0;
            pin_ok_d = 1'b0;
        end
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        card_eject    = (state_q == ST_EJECT);
        card_retained = (state_q == ST_LOCKED);
        pin_ok        = pin_ok_q;
    end

    assign timer_enable  = (state_q == ST_PIN_WAIT) || (state_q == ST_TXN_WAIT);
    assign timer_restart = (state_d != state_q) || (timer_enable && (pin_valid || txn_valid));

    assign dep_sum = {1'b0, balance_q} + {1'b0, amt_q};

    // The transaction commits during the single EXECUTE cycle; results show up on entry to EJECT.
    always_comb begin
        type_d    = type_q;
        amt_d     = amt_q;
        balance_d = balance_q;
        old_d     = old_q;
        new_d     = new_q;
        wd_d      = 1'b0;
        dep_d     = 1'b0;
        err_d     = 1'b0;
        if ((state_q == ST_TXN_WAIT) && (state_d == ST_EXECUTE)) begin
            type_d = txn_t'(txn_type);
            amt_d  = txn_amount;
        end
        if (state_q == ST_EXECUTE) begin
            old_d = balance_q;
            case (type_q)
                TXN_WITHDRAW: begin
                    if (amt_q <= balance_q) begin
                        balance_d = balance_q - amt_q;
                        wd_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                TXN_DEPOSIT: begin
                    if (dep_sum[BAL_W]) begin
                        err_d = 1'b1;
                    end else begin
                        balance_d = dep_sum[BAL_W-1:0];
                        dep_d     = 1'b1;
                    end
                end
                default: ;
            endcase
            new_d = balance_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q    <= TXN_WITHDRAW;
            amt_q     <= '0;
            balance_q <= INIT_BALANCE;
            old_q     <= '0;
            new_q     <= '0;
            wd_q      <= 1'b0;
            dep_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            type_q    <= type_d;
            amt_q     <= amt_d;
            balance_q <= balance_d;
            old_q     <= old_d;
            new_q     <= new_d;
            wd_q      <= wd_d;
            dep_q     <= dep_d;
            err_q     <= err_d;
        end
    end

    assign withdrawal_completed = wd_q;
    assign deposit_completed    = dep_q;
    assign txn_error            = err_q;
    assign old_balance          = old_q;
    assign new_balance          = new_q;

`ifdef ATM_MINI_STATEMENT_EN
    logic [BAL_W-1:0] hist_q [HIST_DEPTH];
    logic [BAL_W-1:0] hist_d [HIST_DEPTH];

    // Entry 0 is the newest; only successful withdraw/deposit pushes.
    always_comb begin
        for (int i = 0; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i];
        if (wd_d || dep_d) begin
            hist_d[0] = new_d;
            for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign mini_statement = hist_q[stmt_idx];
`else
    logic unused_stmt;
    assign unused_stmt    = ^stmt_idx;
    assign mini_statement = '0;
`endif

endmodule

// File: tb/tb_atm_session_sequencer.sv
// Self-checking bench for atm_session_sequencer: scoreboard of expected
// transaction results, plus lockout, timeout, abort and cancel sessions.
module tb_atm_session_sequencer;

    localparam int          TCYC     = 1000;
    localparam logic [15:0] GOOD_PIN = 16'h1234;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_inserted;
    logic        pin_valid;
    logic [15:0] pin_value;
    logic        txn_valid;
    logic [1:0]  txn_type;
    logic [15:0] txn_amount;
    logic [1:0]  stmt_idx;
    logic        pin_ok, card_eject, card_retained;
    logic        withdrawal_completed, deposit_completed, txn_error, busy;
    logic [15:0] old_balance, new_balance, mini_statement;

    typedef struct {
        logic        wd;
        logic        dep;
        logic        err;
        logic [15:0] oldb;
        logic [15:0] newb;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   bal_model;
    int   hist_model[4];
    int   exp_wd = 0, exp_dep = 0, exp_err = 0;
    int   seen_wd = 0, seen_dep = 0, seen_err = 0;

    atm_session_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .card_inserted       (card_inserted),
        .pin_valid           (pin_valid),
        .pin_value           (pin_value),
        .txn_valid           (txn_valid),
        .txn_type            (txn_type),
        .txn_amount          (txn_amount),
        .stmt_idx            (stmt_idx),
        .pin_ok              (pin_ok),
        .card_eject          (card_eject),
        .card_retained       (card_retained),
        .withdrawal_completed(withdrawal_completed),
        .deposit_completed   (deposit_completed),
        .txn_error           (txn_error),
        .old_balance         (old_balance),
        .new_balance         (new_balance),
        .mini_statement      (mini_statement),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (withdrawal_completed === 1'b1) seen_wd++;
        if (deposit_completed === 1'b1) seen_dep++;
        if (txn_error === 1'b1) seen_err++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset         = 1'b1;
        card_inserted = 1'b0;
        pin_valid     = 1'b0;
        pin_value     = '0;
        txn_valid     = 1'b0;
        txn_type      = 2'b00;
        txn_amount    = '0;
        stmt_idx      = 2'b00;
        tick();
        reset     = 1'b0;
        bal_model = 5000;
        for (int i = 0; i < 4; i++) hist_model[i] = 0;
    endtask

    task automatic startSession();
        card_inserted = 1'b1;
        tick();
        checkOutput("busy_after_insert", 32'(busy), 32'd1);
        pin_value = GOOD_PIN;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        checkOutput("pin_ok_after_match", 32'(pin_ok), 32'd1);
    endtask

    task automatic removeCard();
        card_inserted = 1'b0;
        tick();
        checkOutput("busy_after_remove", 32'(busy), 32'd0);
        checkOutput("eject_after_remove", 32'(card_eject), 32'd0);
        checkOutput("pin_ok_after_remove", 32'(pin_ok), 32'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] t, input logic [15:0] amt);
        exp_t e;
        exp_t got;
        e.wd   = 1'b0;
        e.dep  = 1'b0;
        e.err  = 1'b0;
        e.oldb = 16'(bal_model);
        if (t == 2'b00) begin
            if (int'(amt) <= bal_model) begin
                bal_model = bal_model - int'(amt);
                e.wd = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end else if (t == 2'b01) begin
            if (bal_model + int'(amt) > 65535) begin
                e.err = 1'b1;
            end else begin
                bal_model = bal_model + int'(amt);
                e.dep = 1'b1;
            end
        end
        e.newb = 16'(bal_model);
        if (e.wd || e.dep) begin
            for (int i = 3; i > 0; i--) hist_model[i] = hist_model[i-1];
            hist_model[0] = bal_model;
        end
        if (e.wd) exp_wd++;
        if (e.dep) exp_dep++;
        if (e.err) exp_err++;
        sb.push_back(e);

        txn_type   = t;
        txn_amount = amt;
        txn_valid  = 1'b1;
        tick();
        txn_valid = 1'b0;
        checkOutput("no_early_pulse", 32'({withdrawal_completed, deposit_completed, txn_error}), 32'd0);
        tick();
        got = sb.pop_front();
        checkOutput("withdrawal_completed", 32'(withdrawal_completed), 32'(got.wd));
        checkOutput("deposit_completed", 32'(deposit_completed), 32'(got.dep));
        checkOutput("txn_error", 32'(txn_error), 32'(got.err));
        checkOutput("old_balance", 32'(old_balance), 32'(got.oldb));
        checkOutput("new_balance", 32'(new_balance), 32'(got.newb));
        checkOutput("eject_after_txn", 32'(card_eject), 32'd1);
        tick();
        checkOutput("pulse_one_cycle", 32'({withdrawal_completed, deposit_completed, txn_error}), 32'd0);
    endtask

    initial begin
        doReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pin_ok", 32'(pin_ok), 32'd0);
        checkOutput("rst_eject", 32'(card_eject), 32'd0);
        checkOutput("rst_retained", 32'(card_retained), 32'd0);
        checkOutput("rst_pulses", 32'({withdrawal_completed, deposit_completed, txn_error}), 32'd0);
        checkOutput("rst_old", 32'(old_balance), 32'd0);
        checkOutput("rst_new", 32'(new_balance), 32'd0);
        checkOutput("rst_mini", 32'(mini_statement), 32'd0);

        // Withdraw 1200 from 5000; eject held until the card goes.
        startSession();
        applyStimulus(2'b00, 16'd1200);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("eject_held", 32'(card_eject), 32'd1);
        end
        removeCard();

        // Insufficient funds.
        doReset();
        startSession();
        applyStimulus(2'b00, 16'd6000);
        removeCard();

        // Deposit overflow, then good deposit, inquiry and cancel.
        startSession();
        applyStimulus(2'b01, 16'hFFFF);
        removeCard();
        startSession();
        applyStimulus(2'b01, 16'd100);
        removeCard();
        startSession();
        applyStimulus(2'b10, 16'd777);
        removeCard();
        startSession();
        txn_type  = 2'b11;
        txn_valid = 1'b1;
        tick();
        txn_valid = 1'b0;
        checkOutput("cancel_eject", 32'(card_eject), 32'd1);
        tick();
        checkOutput("cancel_no_pulse", 32'({withdrawal_completed, deposit_completed, txn_error}), 32'd0);
        checkOutput("cancel_new_balance", 32'(new_balance), 32'd5100);
        removeCard();

        // Plain inactivity timeout in TXN_WAIT.
        startSession();
        for (int i = 0; i < TCYC - 1; i++) tick();
        checkOutput("timeout_not_yet", 32'(card_eject), 32'd0);
        tick();
        checkOutput("timeout_eject", 32'(card_eject), 32'd1);
        checkOutput("timeout_pin_ok", 32'(pin_ok), 32'd1);
        removeCard();

        // A strobe restarts the timer.
        startSession();
        for (int i = 0; i < 500; i++) tick();
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        for (int i = 0; i < TCYC - 1; i++) tick();
        checkOutput("restart_not_yet", 32'(card_eject), 32'd0);
        tick();
        checkOutput("restart_eject", 32'(card_eject), 32'd1);
        removeCard();

        // Abort in TXN_WAIT beats a same-cycle withdraw.
        startSession();
        card_inserted = 1'b0;
        txn_type      = 2'b00;
        txn_amount    = 16'd10;
        txn_valid     = 1'b1;
        tick();
        txn_valid = 1'b0;
        checkOutput("abort_idle", 32'(busy), 32'd0);
        checkOutput("abort_pin_ok", 32'(pin_ok), 32'd0);
        tick();
        tick();
        checkOutput("abort_no_pulse", 32'({withdrawal_completed, deposit_completed, txn_error}), 32'd0);
        checkOutput("abort_balance", 32'(new_balance), 32'd5100);

        // Three wrong PINs lock the card until reset.
        card_inserted = 1'b1;
        tick();
        pin_value = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            checkOutput("lock_not_yet", 32'(card_retained), 32'd0);
            pin_valid = 1'b1;
            tick();
            pin_valid = 1'b0;
            tick();
        end
        checkOutput("locked_retained", 32'(card_retained), 32'd1);
        pin_value = GOOD_PIN;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        txn_valid = 1'b1;
        tick();
        txn_valid     = 1'b0;
        card_inserted = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkOutput("locked_hold", 32'(card_retained), 32'd1);
        checkOutput("locked_busy", 32'(busy), 32'd1);
        checkOutput("locked_pin_ok", 32'(pin_ok), 32'd0);
        checkOutput("locked_no_eject", 32'(card_eject), 32'd0);
        doReset();
        checkOutput("unlock_by_reset", 32'(card_retained), 32'd0);

        // Mini statement history.
        startSession();
        applyStimulus(2'b00, 16'd100);
        removeCard();
        startSession();
        applyStimulus(2'b01, 16'd50);
        removeCard();
        for (int i = 0; i < 4; i++) begin
            stmt_idx = 2'(i);
            #1;
`ifdef ATM_MINI_STATEMENT_EN
            checkOutput("mini_statement", 32'(mini_statement), 32'(hist_model[i]));
`else
            checkOutput("mini_statement_off", 32'(mini_statement), 32'd0);
`endif
        end

        tick();
        checkOutput("count_withdrawals", 32'(seen_wd), 32'(exp_wd));
        checkOutput("count_deposits", 32'(seen_dep), 32'(exp_dep));
        checkOutput("count_errors", 32'(seen_err), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
